// File: rtl/mem_seq_pkg.sv
// Shared types for the SLC-3 SRAM access sequencer.
package mem_seq_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  typedef logic port_t;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 4;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the port that was not granted last wins.
module rr_arb2
  import mem_seq_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_t      last_i,
  output port_t      gnt_o,
  output logic       vld_o
);
  always_comb begin
    vld_o = |req_i;
    if (req_i == 2'b11) gnt_o = ~last_i;
    else                gnt_o = req_i[1];
  end
endmodule

// File: rtl/mem_sequencer.sv
// Arbitrates the 16-bit SRAM between CPU (port 0) and loader (port 1) and sequences
// the active-low strobes: IDLE -> SETUP -> ACCESS x WAIT -> DONE. WAIT legal range 1..15.
module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int AW   = 16,
  parameter int WAIT = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [15:0]   wdata0,
  input  logic [15:0]   wdata1,
  output logic          done0,
  output logic          done1,
  output logic [15:0]   rdata,
  output logic          busy,
  output logic [AW-1:0] A,
  output logic [15:0]   mem_wdata,
  output logic          mem_drive,
  input  logic [15:0]   mem_rdata,
  output logic          Mem_CE,
  output logic          Mem_OE,
  output logic          Mem_WE,
  output logic          Mem_UB,
  output logic          Mem_LB
);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT - 1);

  state_t           state_q;
  port_t            last_q, port_q, arb_gnt;
  logic             arb_vld;
  logic             we_q, we_d;
  logic [AW-1:0]    a_q, addr_d;
  logic [15:0]      wd_q, wdata_d, rdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       done_q;
  logic             busy_q, drv_q, ce_q, oe_q, wen_q;

  rr_arb2 u_arb (
    .req_i  ({req1, req0}),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .vld_o  (arb_vld)
  );

  assign we_d    = arb_gnt ? we1    : we0;
  assign addr_d  = arb_gnt ? addr1  : addr0;
  assign wdata_d = arb_gnt ? wdata1 : wdata0;

  // Strobes are registered on the transition into each state so they never
  // depend combinationally on req and reset drives them straight to idle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      a_q     <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      drv_q   <= 1'b0;
      ce_q    <= 1'b1;
      oe_q    <= 1'b1;
      wen_q   <= 1'b1;
    end else begin
      done_q <= '0;
      unique case (state_q)
        IDLE: if (arb_vld) begin
          state_q <= SETUP;
          busy_q  <= 1'b1;
          port_q  <= arb_gnt;
          last_q  <= arb_gnt;
          we_q    <= we_d;
          a_q     <= addr_d;
          wd_q    <= wdata_d;
          ce_q    <= 1'b0;
          oe_q    <= we_d;
          drv_q   <= we_d;
        end
        SETUP: begin
          state_q <= ACCESS;
          cnt_q   <= WAIT_LD;
          wen_q   <= ~we_q;
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q        <= DONE;
            oe_q           <= 1'b1;
            wen_q          <= 1'b1;
            done_q[port_q] <= 1'b1;
            if (!we_q) rdata_q <= mem_rdata;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          // CE, A and write data stay put through DONE for write hold time
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ce_q    <= 1'b1;
          drv_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done0     = done_q[0];
  assign done1     = done_q[1];
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign A         = a_q;
  assign mem_wdata = wd_q;
  assign mem_drive = drv_q;
  assign Mem_CE    = ce_q;
  assign Mem_UB    = ce_q;
  assign Mem_LB    = ce_q;
  assign Mem_OE    = oe_q;
  assign Mem_WE    = wen_q;
endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench: WAIT=2 and WAIT=5 sequencers, each on a small behavioural SRAM.
module tb_mem_sequencer;
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  // WAIT=2 instance
  logic        a_req0, a_req1, a_we0, a_we1, a_done0, a_done1, a_busy, a_drv;
  logic [15:0] a_addr0, a_addr1, a_wd0, a_wd1, a_rdata, a_A, a_mwd, a_mrd;
  logic        a_ce, a_oe, a_we, a_ub, a_lb;
  // WAIT=5 instance
  logic        b_req0, b_req1, b_we0, b_we1, b_done0, b_done1, b_busy, b_drv;
  logic [15:0] b_addr0, b_addr1, b_wd0, b_wd1, b_rdata, b_A, b_mwd, b_mrd;
  logic        b_ce, b_oe, b_we, b_ub, b_lb;

  mem_sequencer #(.AW(16), .WAIT(2)) dut_a (
    .Clk(Clk), .Reset(Reset), .req0(a_req0), .req1(a_req1), .we0(a_we0), .we1(a_we1),
    .addr0(a_addr0), .addr1(a_addr1), .wdata0(a_wd0), .wdata1(a_wd1),
    .done0(a_done0), .done1(a_done1), .rdata(a_rdata), .busy(a_busy), .A(a_A),
    .mem_wdata(a_mwd), .mem_drive(a_drv), .mem_rdata(a_mrd),
    .Mem_CE(a_ce), .Mem_OE(a_oe), .Mem_WE(a_we), .Mem_UB(a_ub), .Mem_LB(a_lb));

  mem_sequencer #(.AW(16), .WAIT(5)) dut_b (
    .Clk(Clk), .Reset(Reset), .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
    .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wd0), .wdata1(b_wd1),
    .done0(b_done0), .done1(b_done1), .rdata(b_rdata), .busy(b_busy), .A(b_A),
    .mem_wdata(b_mwd), .mem_drive(b_drv), .mem_rdata(b_mrd),
    .Mem_CE(b_ce), .Mem_OE(b_oe), .Mem_WE(b_we), .Mem_UB(b_ub), .Mem_LB(b_lb));

  // Behavioural SRAMs: read data only while CE and OE are low, write on edges with WE low
  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];
  assign a_mrd = (!a_ce && !a_oe) ? mem_a[a_A[7:0]] : 16'hDEAD;
  assign b_mrd = (!b_ce && !b_oe) ? mem_b[b_A[7:0]] : 16'hDEAD;
  always @(posedge Clk) begin
    if (!a_ce && !a_we && a_drv) mem_a[a_A[7:0]] = a_mwd;
    if (!b_ce && !b_we && b_drv) mem_b[b_A[7:0]] = b_mwd;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-window monitor results
  int          ev_cyc[$];
  int          ev_port[$];
  logic [15:0] ev_rd[$];
  int          oe_lo, we_lo, drv_hi, both_done;
  logic [15:0] cap_A, cap_wd;
  logic        cap_ce;

  task automatic clr_mon();
    ev_cyc.delete(); ev_port.delete(); ev_rd.delete();
    oe_lo = 0; we_lo = 0; drv_hi = 0; both_done = 0;
    cap_A = '0; cap_wd = '0; cap_ce = 1'b1;
  endtask

  // Step cycles [from..to] after the request edge; cycle 1 is SETUP.
  task automatic run(input bit sel, input int from, input int to, input bit drop);
    logic d0, d1;
    for (int c = from; c <= to; c++) begin
      @(posedge Clk); #1;
      if (drop && c == 1) begin
        if (sel) begin b_req0 = 1'b0; b_req1 = 1'b0; end
        else     begin a_req0 = 1'b0; a_req1 = 1'b0; end
      end
      d0 = sel ? b_done0 : a_done0;
      d1 = sel ? b_done1 : a_done1;
      if (!(sel ? b_oe : a_oe)) oe_lo++;
      if (!(sel ? b_we : a_we)) we_lo++;
      if (sel ? b_drv : a_drv)  drv_hi++;
      if (d0 && d1) both_done++;
      if (c == 1) begin
        cap_A  = sel ? b_A   : a_A;
        cap_wd = sel ? b_mwd : a_mwd;
        cap_ce = sel ? b_ce  : a_ce;
      end
      if (d0 || d1) begin
        ev_cyc.push_back(c);
        ev_port.push_back(d1 ? 1 : 0);
        ev_rd.push_back(sel ? b_rdata : a_rdata);
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    {a_req0, a_req1, a_we0, a_we1} = '0;
    {b_req0, b_req1, b_we0, b_we1} = '0;
    a_addr0 = '0; a_addr1 = '0; a_wd0 = '0; a_wd1 = '0;
    b_addr0 = '0; b_addr1 = '0; b_wd0 = '0; b_wd1 = '0;
    for (int i = 0; i < 256; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    mem_a[8'h10] = 16'hBEEF;
    mem_b[8'h40] = 16'hCAFE;
    clr_mon();

    // Reset state
    repeat (2) begin @(posedge Clk); #1; end
    chk("rst_strobes", {a_ce, a_oe, a_we, a_ub, a_lb}, 5'b11111);
    chk("rst_A", a_A, 16'h0);
    chk("rst_wdata", a_mwd, 16'h0);
    chk("rst_drive", a_drv, 1'b0);
    chk("rst_done", {a_done0, a_done1}, 2'b00);
    chk("rst_rdata", a_rdata, 16'h0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_b", {b_ce, b_oe, b_we, b_ub, b_lb, b_drv, b_busy, b_A, b_mwd, b_rdata}, {5'b11111, 2'b00, 48'h0});
    Reset = 1'b0;
    @(posedge Clk); #1;

    // Read 0x0010 from port 0
    clr_mon();
    a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 16'h0010;
    run(0, 1, 6, 1);
    chk("rd_setup_A", cap_A, 16'h0010);
    chk("rd_setup_ce", cap_ce, 1'b0);
    chk("rd_ndone", ev_cyc.size(), 1);
    if (ev_cyc.size() >= 1) begin
      chk("rd_done_cyc", ev_cyc[0], 4);
      chk("rd_done_port", ev_port[0], 0);
      chk("rd_rdata", ev_rd[0], 16'hBEEF);
    end
    chk("rd_oe_lo", oe_lo, 3);
    chk("rd_we_lo", we_lo, 0);
    chk("rd_idle_busy", a_busy, 1'b0);

    // Write 0x1234 to 0x0020 from port 1
    clr_mon();
    a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 16'h0020; a_wd1 = 16'h1234;
    run(0, 1, 6, 1);
    chk("wr_setup_A", cap_A, 16'h0020);
    chk("wr_setup_wd", cap_wd, 16'h1234);
    chk("wr_we_lo", we_lo, 2);
    chk("wr_drv_hi", drv_hi, 4);
    chk("wr_oe_lo", oe_lo, 0);
    chk("wr_ndone", ev_cyc.size(), 1);
    if (ev_cyc.size() >= 1) begin
      chk("wr_done_cyc", ev_cyc[0], 4);
      chk("wr_done_port", ev_port[0], 1);
      chk("wr_rdata_kept", ev_rd[0], 16'hBEEF);
    end
    chk("wr_mem", mem_a[8'h20], 16'h1234);

    // Read back 0x0020
    clr_mon();
    a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 16'h0020;
    run(0, 1, 6, 1);
    chk("rb_ndone", ev_cyc.size(), 1);
    if (ev_rd.size() >= 1) chk("rb_rdata", ev_rd[0], 16'h1234);

    // Fresh reset, then both ports held: grants alternate starting with port 0
    Reset = 1'b1; #1;
    chk("rr_rst_busy", a_busy, 1'b0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    clr_mon();
    a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 16'h0010;
    a_req1 = 1'b1; a_we1 = 1'b0; a_addr1 = 16'h0020;
    run(0, 1, 20, 0);
    a_req0 = 1'b0; a_req1 = 1'b0;
    run(0, 21, 24, 0);
    chk("rr_ndone", ev_cyc.size(), 4);
    chk("rr_both", both_done, 0);
    for (int i = 0; i < ev_cyc.size() && i < 4; i++) begin
      chk($sformatf("rr_cyc%0d", i), ev_cyc[i], 4 + 5 * i);
      chk($sformatf("rr_port%0d", i), ev_port[i], i % 2);
      chk($sformatf("rr_rd%0d", i), ev_rd[i], (i % 2) ? 16'h1234 : 16'hBEEF);
    end

    // req0 held alone for three accesses: done0 every 5 cycles
    clr_mon();
    a_req0 = 1'b1; a_addr0 = 16'h0010;
    run(0, 1, 14, 0);
    a_req0 = 1'b0;
    run(0, 15, 18, 0);
    chk("hold_ndone", ev_cyc.size(), 3);
    for (int i = 0; i < ev_cyc.size() && i < 3; i++) begin
      chk($sformatf("hold_cyc%0d", i), ev_cyc[i], 4 + 5 * i);
      chk($sformatf("hold_port%0d", i), ev_port[i], 0);
    end
    chk("hold_idle", a_busy, 1'b0);

    // Reset in the second ACCESS cycle of a write
    clr_mon();
    a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 16'h0030; a_wd1 = 16'h5555;
    run(0, 1, 3, 1);
    chk("mid_we_low", a_we, 1'b0);
    Reset = 1'b1; #1;
    chk("mid_rst_we", a_we, 1'b1);
    chk("mid_rst_ce", a_ce, 1'b1);
    chk("mid_rst_drv", a_drv, 1'b0);
    chk("mid_rst_busy", a_busy, 1'b0);
    chk("mid_rst_A", a_A, 16'h0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    clr_mon();
    run(0, 1, 4, 0);
    chk("mid_no_done", ev_cyc.size(), 0);
    clr_mon();
    a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 16'h0010;
    run(0, 1, 6, 1);
    chk("post_ndone", ev_cyc.size(), 1);
    if (ev_cyc.size() >= 1) begin
      chk("post_cyc", ev_cyc[0], 4);
      chk("post_rdata", ev_rd[0], 16'hBEEF);
    end

    // WAIT=5 instance: read, then a write that must leave rdata alone
    clr_mon();
    b_req0 = 1'b1; b_we0 = 1'b0; b_addr0 = 16'h0040;
    run(1, 1, 9, 1);
    chk("w5_rd_ndone", ev_cyc.size(), 1);
    if (ev_cyc.size() >= 1) begin
      chk("w5_rd_cyc", ev_cyc[0], 7);
      chk("w5_rd_rdata", ev_rd[0], 16'hCAFE);
    end
    chk("w5_rd_oe_lo", oe_lo, 6);
    clr_mon();
    b_req1 = 1'b1; b_we1 = 1'b1; b_addr1 = 16'h0041; b_wd1 = 16'h7777;
    run(1, 1, 9, 1);
    chk("w5_wr_ndone", ev_cyc.size(), 1);
    if (ev_cyc.size() >= 1) begin
      chk("w5_wr_cyc", ev_cyc[0], 7);
      chk("w5_wr_port", ev_port[0], 1);
    end
    chk("w5_wr_we_lo", we_lo, 5);
    chk("w5_rdata_kept", b_rdata, 16'hCAFE);
    chk("w5_wr_mem", mem_b[8'h41], 16'h7777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
